demux_1x8_seq: RTL and testbench

// Registered 1-to-8 demultiplexer with valid/ready handshake; the receive-side counterpart of mux_8x1.

---
 rtl/demux_1x8_seq_if.sv | 35 +++
 rtl/demux_1x8_seq.sv | 123 ++++++++++++
 tb/tb_demux_1x8_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/demux_1x8_seq_if.sv
// Handshake and lane bus of the demux_1x8_seq block.
// The slave modport is the demux itself; the master modport is the producer and frame consumer side.
interface demux_1x8_seq_if #(
  parameter int unsigned WIDTH = 1
) ();
  logic [WIDTH-1:0] din;
  logic             s2;
  logic             s1;
  logic             s0;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;
  logic [WIDTH-1:0] y3;
  logic [WIDTH-1:0] y4;
  logic [WIDTH-1:0] y5;
  logic [WIDTH-1:0] y6;
  logic [WIDTH-1:0] y7;
  logic [7:0]       lane_strobe;
  logic             out_valid;
  logic             out_ready;
  logic             frame_par;

  modport slave (
    input  din, s2, s1, s0, mode, in_valid, out_ready,
    output in_ready, y0, y1, y2, y3, y4, y5, y6, y7, lane_strobe, out_valid, frame_par
  );

  modport master (
    output din, s2, s1, s0, mode, in_valid, out_ready,
    input  in_ready, y0, y1, y2, y3, y4, y5, y6, y7, lane_strobe, out_valid, frame_par
  );
endinterface

// File: rtl/demux_1x8_seq.sv
// Registered 1-to-8 demultiplexer with valid/ready handshake: explicit lane select or auto frame fill.
// Optional frame parity output is built only when DEMUX_PARITY_EN is defined.
module demux_1x8_seq #(
  parameter int unsigned WIDTH = 1,
  parameter bit          HOLD  = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  demux_1x8_seq_if.slave bus
);

  logic [7:0][WIDTH-1:0] y_q;
  logic [7:0][WIDTH-1:0] y_d;
  logic [7:0]            strobe_q;
  logic [7:0]            strobe_d;
  logic [2:0]            idx_q;
  logic [2:0]            idx_d;
  logic                  out_valid_q;
  logic                  out_valid_d;
  logic                  accept_s;
  logic                  frame_done_s;
  logic [2:0]            lane_s;

  // A held frame blocks input unless the consumer takes it in this same cycle.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept_s     = bus.in_valid && bus.in_ready;
  assign lane_s       = bus.mode ? idx_q : {bus.s2, bus.s1, bus.s0};

  // Next-state for lanes, strobe, fill index and frame-valid flag.
  always_comb begin
    y_d          = y_q;
    strobe_d     = 8'd0;
    idx_d        = idx_q;
    out_valid_d  = out_valid_q;
    frame_done_s = 1'b0;
    if (accept_s) begin
      if (!HOLD && !bus.mode) begin
        y_d = {(8 * WIDTH){1'b0}};
      end else begin
        y_d = y_q;
      end
      y_d[lane_s] = bus.din;
      strobe_d    = 8'd1 << lane_s;
      if (bus.mode) begin
        idx_d        = idx_q + 3'd1;
        frame_done_s = (idx_q == 3'd7);
      end else begin
        idx_d = 3'd0;
      end
    end else if (!bus.mode) begin
      idx_d = 3'd0;
    end else begin
      idx_d = idx_q;
    end
    // A frame completing on the release edge keeps out_valid high.
    if (frame_done_s) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= {(8 * WIDTH){1'b0}};
      strobe_q    <= 8'd0;
      idx_q       <= 3'd0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      strobe_q    <= strobe_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.y0          = y_q[0];
  assign bus.y1          = y_q[1];
  assign bus.y2          = y_q[2];
  assign bus.y3          = y_q[3];
  assign bus.y4          = y_q[4];
  assign bus.y5          = y_q[5];
  assign bus.y6          = y_q[6];
  assign bus.y7          = y_q[7];
  assign bus.lane_strobe = strobe_q;
  assign bus.out_valid   = out_valid_q;

`ifdef DEMUX_PARITY_EN
  logic par_q;
  logic par_d;

  function automatic logic frame_parity(input logic [7:0][WIDTH-1:0] lanes);
    return ^lanes;
  endfunction

  // Parity tracks the frame being raised, or every explicit-mode write.
  always_comb begin
    par_d = par_q;
    if (frame_done_s || (accept_s && !bus.mode)) begin
      par_d = frame_parity(y_d);
    end else begin
      par_d = par_q;
    end
  end

  // Parity register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign bus.frame_par = par_q;
`else
  assign bus.frame_par = 1'b0;
`endif

endmodule

// File: tb/tb_demux_1x8_seq.sv
// Self-checking bench for demux_1x8_seq: directed scenarios followed by randomized traffic,
// all compared against a frame-level reference model.
module tb_demux_1x8_seq;
  localparam int unsigned WIDTH = 1;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  demux_1x8_seq_if #(.WIDTH(WIDTH)) bus ();

  demux_1x8_seq #(.WIDTH(WIDTH), .HOLD(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: lane contents, samples collected into the current frame, pending frame flag.
  logic [WIDTH-1:0] m_y [8];
  logic [7:0]       m_strobe;
  bit               m_ov;
  bit               m_par;
  logic [WIDTH-1:0] m_frame [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8*WIDTH-1:0] model_lanes();
    logic [8*WIDTH-1:0] v;
    for (int i = 0; i < 8; i++) v[i*WIDTH +: WIDTH] = m_y[i];
    return v;
  endfunction

  function automatic logic expected_par();
`ifdef DEMUX_PARITY_EN
    return m_par;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_y[i] = '0;
    m_strobe = 8'd0;
    m_ov     = 1'b0;
    m_par    = 1'b0;
    m_frame.delete();
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_y"}, {bus.y7, bus.y6, bus.y5, bus.y4, bus.y3, bus.y2, bus.y1, bus.y0}, model_lanes());
    check_eq({tag, "_strobe"}, bus.lane_strobe, m_strobe);
    check_eq({tag, "_out_valid"}, bus.out_valid, m_ov);
    check_eq({tag, "_frame_par"}, bus.frame_par, expected_par());
  endtask

  // Drive one cycle of inputs (called at the falling edge), advance the model at the rising edge.
  task automatic cycle(input string tag, input logic [WIDTH-1:0] d, input logic [2:0] sel,
                       input logic md, input logic iv, input logic ordy);
    bit accept;
    bit fin;
    logic [WIDTH-1:0] acc;
    bus.din = d;
    {bus.s2, bus.s1, bus.s0} = sel;
    bus.mode      = md;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    #1;
    check_eq({tag, "_in_ready"}, bus.in_ready, !m_ov || ordy);
    @(posedge clk);
    accept   = iv && (!m_ov || ordy);
    fin      = 1'b0;
    m_strobe = 8'd0;
    if (accept) begin
      if (md) begin
        m_strobe[m_frame.size()] = 1'b1;
        m_y[m_frame.size()]      = d;
        m_frame.push_back(d);
        if (m_frame.size() == 8) begin
          fin = 1'b1;
          m_frame.delete();
        end
      end else begin
        m_y[sel]      = d;
        m_strobe[sel] = 1'b1;
      end
    end
    if (!md) m_frame.delete();
    if (fin) m_ov = 1'b1;
    else if (m_ov && ordy) m_ov = 1'b0;
    if (fin || (accept && !md)) begin
      acc = '0;
      for (int i = 0; i < 8; i++) acc = acc ^ m_y[i];
      m_par = ^acc;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] pat;
    logic       md;
    rst_n         = 1'b0;
    bus.din       = '0;
    bus.s2        = 1'b0;
    bus.s1        = 1'b0;
    bus.s0        = 1'b0;
    bus.mode      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Explicit write to lane 5, then strobe must drop.
    cycle("t1", 1'b1, 3'd5, 1'b0, 1'b1, 1'b0);
    check_eq("t1_y5", bus.y5, 1'b1);
    check_eq("t1_strobe5", bus.lane_strobe, 8'b0010_0000);
    cycle("t1_idle", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Auto frame 1,0,1,1,0,0,1,0 with consumer not ready.
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) cycle("t2", pat[i], 3'd0, 1'b1, 1'b1, 1'b0);
    check_eq("t2_lanes", {bus.y7, bus.y6, bus.y5, bus.y4, bus.y3, bus.y2, bus.y1, bus.y0}, pat);
    check_eq("t2_out_valid", bus.out_valid, 1'b1);
    check_eq("t2_in_ready", bus.in_ready, 1'b0);
`ifdef DEMUX_PARITY_EN
    check_eq("t2_par", bus.frame_par, 1'b0);
`endif

    // Backpressure, then release with a same-cycle accept.
    for (int i = 0; i < 5; i++) cycle("t3_hold", 1'($urandom), 3'd0, 1'b1, 1'b1, 1'b0);
    cycle("t3_rel", 1'b1, 3'd0, 1'b1, 1'b1, 1'b1);
    check_eq("t3_out_valid", bus.out_valid, 1'b0);
    check_eq("t3_y0", bus.y0, 1'b1);
    cycle("t3_idx", 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    check_eq("t3_idx1", bus.lane_strobe, 8'b0000_0010);

    // Mode change discards the partial frame.
    cycle("t4_acc", 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    cycle("t4_sw", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    cycle("t4_first", 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    check_eq("t4_lane0", bus.lane_strobe, 8'b0000_0001);
    for (int i = 0; i < 7; i++) begin
      check_eq("t4_no_frame", bus.out_valid, 1'b0);
      cycle("t4_fill", 1'($urandom), 3'($urandom), 1'b1, 1'b1, 1'b0);
    end
    check_eq("t4_frame", bus.out_valid, 1'b1);
    cycle("t4_release", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 4; i++) cycle("t5_acc", 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("t5_reset");
    #1;
    rst_n = 1'b1;
    cycle("t5_after", 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    check_eq("t5_lane0", bus.lane_strobe, 8'b0000_0001);
    for (int i = 0; i < 7; i++) cycle("t5_fill", 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    cycle("t5_release", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);

    // Odd-weight frame.
    pat = 8'b0000_0111;
    for (int i = 0; i < 8; i++) cycle("t6", pat[i], 3'd0, 1'b1, 1'b1, 1'b0);
`ifdef DEMUX_PARITY_EN
    check_eq("t6_par", bus.frame_par, 1'b1);
`endif
    cycle("t6_release", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);

    // Randomized traffic with sticky mode and random backpressure.
    md = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15, 0) == 0) md = ~md;
      cycle("rand", WIDTH'($urandom), 3'($urandom), md,
            1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
